// File: rtl/dot_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dot_row_scheduler
// Description : Issues the chunk reads of a row-by-row dot-product job and
//               tags each issued chunk so that the accumulated value of the
//               last chunk of every row is returned as one row result.
//               A job covers rows x chunks consecutive chunk addresses
//               starting at job_base. The address wraps silently at AW bits.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   job_valid/ready : job handshake, ready only while idle
//   job_base        : first chunk address of the job
//   job_rows        : number of rows in the job
//   job_chunks      : number of chunks per row
//   rd_en, rd_addr  : chunk read issue and its address
//   chunk_first     : first chunk of a row (accumulator starts from zero)
//   acc_start       : datapath enable while issuing or draining
//   stall           : holds issue, counters and address
//   abort           : drops the job, clears the tag pipeline, no done
//   acc_result      : accumulated value from the adder tree datapath
//   res_valid/row/data : one registered result per row, ascending order
//   done            : one-cycle completion pulse
//   perf_cycles     : (DOT_ROW_SCHED_PERF_EN only) cycles spent in ISSUE
//                     and DRAIN for the current or last job, saturating
//
// Optional build macro: DOT_ROW_SCHED_PERF_EN adds the perf_cycles port.
//
// Timing: for a chunk issued in cycle t the tag leaves the pipeline in cycle
// t+LAT-1, acc_result is captured on the edge closing that cycle, and the
// row result is presented in cycle t+LAT.
//
// Revision    : 1.0 - initial release
// ============================================================================
module dot_row_scheduler #(
    parameter int NI  = 8,
    parameter int LAT = 13,
    parameter int AW  = 12,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [AW-1:0] job_base,
    input  logic [CW-1:0] job_rows,
    input  logic [CW-1:0] job_chunks,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          chunk_first,
    output logic          acc_start,
    input  logic          stall,
    input  logic          abort,
    input  logic [31:0]   acc_result,
    output logic          res_valid,
    output logic [CW-1:0] res_row,
    output logic [31:0]   res_data,
    output logic          done
`ifdef DOT_ROW_SCHED_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    // Registered tag stages; the result output register is the final stage.
    localparam int TD = LAT - 1;

    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;

    generate
        if (LAT < 2 || NI < 1) begin : g_param_check
            $error("dot_row_scheduler: LAT must be >= 2 and NI >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] chunk_q, chunk_d;
    logic [CW-1:0] rows_q, rows_d;
    logic [CW-1:0] chunks_q, chunks_d;

    logic [TD-1:0] tv_q, tv_d;
    logic [TD-1:0] tl_q, tl_d;
    logic [CW-1:0] tr_q [TD];
    logic [CW-1:0] tr_d [TD];

    logic          res_valid_q, res_valid_d;
    logic [CW-1:0] res_row_q, res_row_d;
    logic [31:0]   res_data_q, res_data_d;

    logic          issue;
    logic          accept;
    logic          last_chunk;
    logic          last_row;
    logic          emerge;

    assign last_chunk = (chunk_q == (chunks_q - CNT_ONE));
    assign last_row   = (row_q == (rows_q - CNT_ONE));
    assign emerge     = tv_q[TD-1] & tl_q[TD-1];

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        row_d    = row_q;
        chunk_d  = chunk_q;
        rows_d   = rows_q;
        chunks_d = chunks_q;
        issue    = 1'b0;
        accept   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (job_valid && !abort) begin
                    accept   = 1'b1;
                    rows_d   = job_rows;
                    chunks_d = job_chunks;
                    addr_d   = job_base;
                    row_d    = '0;
                    chunk_d  = '0;
                    // An empty job still completes with a done pulse.
                    if (job_rows == '0 || job_chunks == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    issue = 1'b1;
                    // Chunks are laid out row-major and contiguous, so the
                    // address is a running count rather than row*chunks+chunk.
                    addr_d = addr_q + ADDR_ONE;
                    if (last_chunk) begin
                        chunk_d = '0;
                        if (last_row) begin
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + CNT_ONE;
                        end
                    end else begin
                        chunk_d = chunk_q + CNT_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (tv_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            issue   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline and result capture
    // ------------------------------------------------------------------
    always_comb begin
        tv_d = '0;
        tl_d = '0;
        tr_d = '{default: '0};

        tv_d[0] = issue;
        tl_d[0] = issue & last_chunk;
        tr_d[0] = row_q;
        for (int i = 1; i < TD; i++) begin
            tv_d[i] = tv_q[i-1];
            tl_d[i] = tl_q[i-1];
            tr_d[i] = tr_q[i-1];
        end

        if (abort) begin
            tv_d = '0;
            tl_d = '0;
        end

        res_valid_d = emerge & ~abort;
        res_row_d   = res_row_q;
        res_data_d  = res_data_q;
        if (emerge && !abort) begin
            res_row_d  = tr_q[TD-1];
            res_data_d = acc_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            row_q       <= '0;
            chunk_q     <= '0;
            rows_q      <= '0;
            chunks_q    <= '0;
            tv_q        <= '0;
            tl_q        <= '0;
            tr_q        <= '{default: '0};
            res_valid_q <= 1'b0;
            res_row_q   <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            row_q       <= row_d;
            chunk_q     <= chunk_d;
            rows_q      <= rows_d;
            chunks_q    <= chunks_d;
            tv_q        <= tv_d;
            tl_q        <= tl_d;
            tr_q        <= tr_d;
            res_valid_q <= res_valid_d;
            res_row_q   <= res_row_d;
            res_data_q  <= res_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign job_ready   = (state_q == S_IDLE);
    assign rd_en       = issue;
    assign rd_addr     = addr_q;
    assign chunk_first = issue & (chunk_q == '0);
    assign acc_start   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    // A result or done already registered for this cycle is masked by abort.
    assign res_valid   = res_valid_q & ~abort;
    assign res_row     = res_row_q;
    assign res_data    = res_data_q;
    assign done        = (state_q == S_DONE) & ~abort;

`ifdef DOT_ROW_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if (acc_start && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dot_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dot_row_scheduler
// Description : Scoreboard bench for dot_row_scheduler. Jobs are expanded
//               into the expected chunk address list; row results are
//               expected LAT cycles after the last chunk of each row issues,
//               carrying the acc_result value driven one cycle earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dot_row_scheduler;

    localparam int LAT = 13;
    localparam int AW  = 12;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [AW-1:0] job_base = '0;
    logic [CW-1:0] job_rows = '0;
    logic [CW-1:0] job_chunks = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          chunk_first;
    logic          acc_start;
    logic          stall = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   acc_result;
    logic          res_valid;
    logic [CW-1:0] res_row;
    logic [31:0]   res_data;
    logic          done;
`ifdef DOT_ROW_SCHED_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    dot_row_scheduler #(.NI(8), .LAT(LAT), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_base(job_base),
        .job_rows(job_rows), .job_chunks(job_chunks),
        .rd_en(rd_en), .rd_addr(rd_addr), .chunk_first(chunk_first),
        .acc_start(acc_start), .stall(stall), .abort(abort),
        .acc_result(acc_result), .res_valid(res_valid), .res_row(res_row),
        .res_data(res_data), .done(done)
`ifdef DOT_ROW_SCHED_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] accf(input int c);
        logic [31:0] v;
        v = c;
        return (v * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    assign acc_result = accf(cyc);

    typedef struct { logic [AW-1:0] addr; bit first; bit last; int row; } iss_t;
    typedef struct { int due; int row; logic [31:0] data; } res_t;

    iss_t exp_iss[$];
    res_t pend[$];

    int total = 0;
    int bad = 0;
    bit done_exp = 0;
    bit done_seen = 0;
    int done_cyc = 0;
    int last_res_cyc = 0;
    int res_count = 0;
    int done_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an issue, result or done.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                if (exp_iss.size() == 0) begin
                    chk("unexpected_rd_en", 1, 0);
                end else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    chk("rd_addr", rd_addr, e.addr);
                    chk("chunk_first", chunk_first, e.first);
                    if (e.last) pend.push_back('{due: cyc + LAT, row: e.row, data: accf(cyc + LAT - 1)});
                end
            end
            if (res_valid) begin
                res_count++;
                last_res_cyc = cyc;
                if (pend.size() == 0) begin
                    chk("unexpected_res_valid", 1, 0);
                end else begin
                    res_t r;
                    r = pend.pop_front();
                    chk("res_cycle", cyc, r.due);
                    chk("res_row", res_row, r.row);
                    chk("res_data", res_data, r.data);
                end
            end
            if (pend.size() > 0 && cyc > pend[0].due) begin
                chk("res_missing", 0, 1);
                void'(pend.pop_front());
            end
            if (done) begin
                done_count++;
                chk("done_expected", done_exp, 1);
                done_exp  = 0;
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic push_job(input logic [AW-1:0] base, input int rows, input int chunks);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < chunks; c++) begin
                logic [AW-1:0] a;
                a = base + AW'(r * chunks + c);
                exp_iss.push_back('{addr: a, first: (c == 0), last: (c == chunks - 1), row: r});
            end
    endtask

    // Called at posedge+2 with the DUT idle; returns the acceptance cycle.
    task automatic start_job(input logic [AW-1:0] base, input int rows, input int chunks, output int acc_cyc);
        push_job(base, rows, chunks);
        done_exp   = 1;
        done_seen  = 0;
        job_base   = base;
        job_rows   = rows[CW-1:0];
        job_chunks = chunks[CW-1:0];
        job_valid  = 1;
        acc_cyc    = cyc;
        @(posedge clk); #2;
        job_valid  = 0;
    endtask

    // mode 1: stall for two cycles after the second chunk issues.
    task automatic run_job(input logic [AW-1:0] base, input int rows, input int chunks,
                           input int mode, input int sp);
        int acc_cyc;
        int scnt;
        int issued;
        scnt = 0;
        start_job(base, rows, chunks, acc_cyc);
        for (int k = 0; k < 800 && !done_seen; k++) begin
            issued = rows * chunks - exp_iss.size();
            if (mode == 1 && issued == 2 && scnt < 2) begin
                logic [AW-1:0] hold;
                hold  = exp_iss[0].addr;
                stall = 1;
                scnt++;
                @(negedge clk);
                chk("stall_rd_en", rd_en, 0);
                chk("stall_addr_hold", rd_addr, hold);
            end else begin
                stall = (sp > 0) && ($urandom_range(0, 99) < sp);
                job_valid  = (exp_iss.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                job_base   = AW'($urandom);
                job_rows   = CW'($urandom);
                job_chunks = CW'($urandom);
            end
            @(posedge clk); #2;
        end
        stall = 0;
        job_valid = 0;
        chk("done_seen", done_seen, 1);
        chk("issues_left", exp_iss.size(), 0);
        chk("results_left", pend.size(), 0);
        if (rows * chunks == 0)
            chk("empty_job_done_window", (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1);
        else
            chk("done_after_last_res", done_cyc, last_res_cyc + 1);
        exp_iss.delete();
        pend.delete();
        done_exp = 0;
        @(posedge clk); #2;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_job_ready"}, job_ready, 1);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_chunk_first"}, chunk_first, 0);
        chk({tag, "_acc_start"}, acc_start, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_res_row"}, res_row, 0);
        chk({tag, "_res_data"}, res_data, 0);
    endtask

    initial begin
        int acc_cyc;
        int nres;
        int ndone;
        int budget;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk_reset_outputs("reset");
        rst = 0;
        @(posedge clk); #2;

        // Directed jobs
        run_job(12'h010, 2, 3, 0, 0);
        run_job(12'h040, 1, 4, 1, 0);
        run_job(12'h080, 0, 5, 0, 0);
        run_job(12'h090, 3, 0, 0, 0);
        run_job(12'hFFE, 1, 4, 0, 0);

        // Randomized jobs with random stall and ignored job_valid traffic
        for (int j = 0; j < 8; j++)
            run_job(AW'($urandom), $urandom_range(1, 4), $urandom_range(1, 5), 0, $urandom_range(0, 40));

        // Abort during DRAIN with a result still outstanding
        start_job(12'h100, 2, 2, acc_cyc);
        budget = 0;
        while (exp_iss.size() > 0 && budget < 100) begin
            @(posedge clk); #2;
            budget++;
        end
        chk("abort_result_outstanding", pend.size() > 0, 1);
        abort = 1;
        pend.delete();
        done_exp = 0;
        nres  = res_count;
        ndone = done_count;
        @(negedge clk);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #2;
        abort = 0;
        @(negedge clk);
        chk("ready_after_abort", job_ready, 1);
        repeat (LAT + 4) @(posedge clk);
        #2;
        chk("no_res_after_abort", res_count, nres);
        chk("no_done_after_abort", done_count, ndone);

        // Asynchronous reset in the middle of ISSUE
        start_job(12'h200, 3, 4, acc_cyc);
        repeat (3) @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk_reset_outputs("midrst");
        exp_iss.delete();
        pend.delete();
        done_exp = 0;
        ndone = done_count;
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
        chk("no_done_after_reset", done_count, ndone);
        @(posedge clk); #2;
        run_job(12'h300, 2, 2, 0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
